// File: rtl/punc_pkg.sv
// PUnC sequencer shared types: opcodes, FSM states,
// select encodings and the packed datapath control word.
package punc_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_RSV = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_EXEC2  = 4'd4,
    S_PAUSE  = 4'd5,
    S_HALT   = 4'd6,
    S_FAULT  = 4'd7
  } state_e;

  localparam int PC_SEL_W = 2;
  localparam int MADDR_W  = 2;
  localparam int WDATA_W  = 2;
  localparam int ALU_W    = 2;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_RF_R1 = 2'd0,
    PC_SEL_OFF9  = 2'd1,
    PC_SEL_OFF11 = 2'd2
  } pc_sel_e;

  typedef enum logic [MADDR_W-1:0] {
    MA_PC      = 2'd0,
    MA_PC_OFF9 = 2'd1,
    MA_R1_OFF6 = 2'd2,
    MA_PREV    = 2'd3
  } maddr_e;

  typedef enum logic [WDATA_W-1:0] {
    WD_ALU     = 2'd0,
    WD_PC_OFF9 = 2'd1,
    WD_MEM     = 2'd2,
    WD_PC      = 2'd3
  } wdata_e;

  typedef enum logic {
    WA_DR = 1'b0,
    WA_R7 = 1'b1
  } waddr_e;

  typedef enum logic {
    R0_SR2 = 1'b0,
    R0_SR  = 1'b1
  } r0addr_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } alu_sel_e;

  typedef enum logic {
    AV_REG  = 1'b0,
    AV_IMM5 = 1'b1
  } alu_val_e;

  typedef struct packed {
    logic     ir_clr;
    logic     ir_ld;
    logic     pc_ld;
    logic     pc_clr;
    logic     pc_inc;
    pc_sel_e  pc_sel;
    maddr_e   mem_r_addr_sel;
    maddr_e   mem_w_addr_sel;
    wdata_e   rf_w_data_sel;
    waddr_e   rf_w_addr_sel;
    r0addr_e  rf_r0_addr_sel;
    logic     rf_w_wr;
    logic     rf_r0_rd;
    logic     rf_r1_rd;
    logic     prev_ld;
    logic     nzp_ld;
    logic     nzp_clr;
    alu_sel_e alu_sel;
    alu_val_e alu_first_val;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
           (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic op_has_exec2(input logic [3:0] op);
    return (op == OP_JSR) || (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/punc_mem_timer.sv
// Memory wait counter; expire flags a request that has
// waited MEM_TIMEOUT cycles without ack (0 = never).
module punc_mem_timer
  import punc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (MEM_TIMEOUT != 0) &&
                  (cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/punc_seq_ctrl.sv
// PUnC LC3 control sequencer over a req/ack memory port,
// with timeout fault, HALT, debug pause/step and retire pulse.
module punc_seq_ctrl
  import punc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ir,
  input  logic              nzp_match,
  input  logic              mem_ack,
  input  logic              dbg_pause,
  input  logic              dbg_step,
  output logic [CTRL_W-1:0] ctrl,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        state_o,
  output logic              halted,
  output logic              fault,
  output logic              retired
);

  state_e     state, state_nx, end_nx;
  ctrl_t      c;
  logic [3:0] op;
  logic       imm, jsr_off, ir_unused;
  logic       expire, tmr_clr, tmr_en;

  assign op        = ir[DATA_W-1 -: 4];
  assign imm       = ir[5];
  assign jsr_off   = ir[11];
  assign ir_unused = ^ir;

  // a new request sequence starts after any idle or acked cycle
  assign tmr_clr = !mem_req || mem_ack;
  assign tmr_en  = mem_req && !mem_ack;

  punc_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nx;
  end

  assign end_nx = dbg_pause ? S_PAUSE : S_FETCH;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:   state_nx = end_nx;
      S_FETCH: begin
        if (mem_ack)     state_nx = S_DECODE;
        else if (expire) state_nx = S_FAULT;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (op == OP_HLT) begin
          state_nx = S_HALT;
        end else if (op_is_mem(op) && !mem_ack) begin
          if (expire) state_nx = S_FAULT;
        end else if (op_has_exec2(op)) begin
          state_nx = S_EXEC2;
        end else begin
          state_nx = end_nx;
        end
      end
      S_EXEC2: begin
        if (op_is_mem(op) && !mem_ack) begin
          if (expire) state_nx = S_FAULT;
        end else begin
          state_nx = end_nx;
        end
      end
      S_PAUSE: begin
        if (dbg_step || !dbg_pause) state_nx = S_FETCH;
      end
      S_HALT:   state_nx = S_HALT;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_INIT;
    endcase
  end

  always_comb begin
    c       = '0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    retired = 1'b0;
    unique case (state)
      S_INIT: begin
        c.pc_clr  = 1'b1;
        c.ir_clr  = 1'b1;
        c.nzp_clr = 1'b1;
      end
      S_FETCH: begin
        mem_req          = 1'b1;
        c.mem_r_addr_sel = MA_PC;
        c.ir_ld          = mem_ack;
        c.pc_inc         = mem_ack;
      end
      S_EXEC: begin
        unique case (op)
          OP_ADD, OP_AND: begin
            c.rf_r1_rd       = 1'b1;
            c.rf_r0_rd       = !imm;
            c.rf_r0_addr_sel = R0_SR2;
            c.alu_first_val  = imm ? AV_IMM5 : AV_REG;
            c.alu_sel        = (op == OP_ADD) ? ALU_ADD : ALU_AND;
            c.rf_w_data_sel  = WD_ALU;
            c.rf_w_addr_sel  = WA_DR;
            c.rf_w_wr        = 1'b1;
            c.nzp_ld         = 1'b1;
            retired          = 1'b1;
          end
          OP_NOT: begin
            c.rf_r1_rd      = 1'b1;
            c.alu_sel       = ALU_NOT;
            c.rf_w_data_sel = WD_ALU;
            c.rf_w_wr       = 1'b1;
            c.nzp_ld        = 1'b1;
            retired         = 1'b1;
          end
          OP_BR: begin
            c.pc_sel = PC_SEL_OFF9;
            c.pc_ld  = nzp_match;
            retired  = 1'b1;
          end
          OP_JMP: begin
            c.rf_r1_rd = 1'b1;
            c.pc_sel   = PC_SEL_RF_R1;
            c.pc_ld    = 1'b1;
            retired    = 1'b1;
          end
          OP_LEA: begin
            c.rf_w_data_sel = WD_PC_OFF9;
            c.rf_w_wr       = 1'b1;
            c.nzp_ld        = 1'b1;
            retired         = 1'b1;
          end
          OP_LD, OP_LDR: begin
            mem_req          = 1'b1;
            c.rf_r1_rd       = (op == OP_LDR);
            c.mem_r_addr_sel = (op == OP_LDR) ? MA_R1_OFF6 : MA_PC_OFF9;
            c.rf_w_data_sel  = WD_MEM;
            c.rf_w_wr        = mem_ack;
            c.nzp_ld         = mem_ack;
            retired          = mem_ack;
          end
          OP_ST, OP_STR: begin
            mem_req          = 1'b1;
            mem_we           = 1'b1;
            c.rf_r1_rd       = (op == OP_STR);
            c.mem_w_addr_sel = (op == OP_STR) ? MA_R1_OFF6 : MA_PC_OFF9;
            c.rf_r0_rd       = 1'b1;
            c.rf_r0_addr_sel = R0_SR;
            retired          = mem_ack;
          end
          OP_LDI, OP_STI: begin
            // both start by reading the pointer into prev
            mem_req          = 1'b1;
            c.mem_r_addr_sel = MA_PC_OFF9;
            c.prev_ld        = mem_ack;
          end
          OP_JSR: begin
            c.rf_w_data_sel = WD_PC;
            c.rf_w_addr_sel = WA_R7;
            c.rf_w_wr       = 1'b1;
          end
          default: retired = 1'b1;
        endcase
      end
      S_EXEC2: begin
        unique case (op)
          OP_JSR: begin
            c.pc_sel   = jsr_off ? PC_SEL_OFF11 : PC_SEL_RF_R1;
            c.rf_r1_rd = !jsr_off;
            c.pc_ld    = 1'b1;
            retired    = 1'b1;
          end
          OP_LDI: begin
            mem_req          = 1'b1;
            c.mem_r_addr_sel = MA_PREV;
            c.rf_w_data_sel  = WD_MEM;
            c.rf_w_wr        = mem_ack;
            c.nzp_ld         = mem_ack;
            retired          = mem_ack;
          end
          OP_STI: begin
            mem_req          = 1'b1;
            mem_we           = 1'b1;
            c.mem_w_addr_sel = MA_PREV;
            c.rf_r0_rd       = 1'b1;
            c.rf_r0_addr_sel = R0_SR;
            retired          = mem_ack;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctrl    = c;
  assign state_o = state;
  assign halted  = (state == S_HALT);
  assign fault   = (state == S_FAULT);

endmodule

// File: tb/tb_punc_seq_ctrl.sv
// Bench for punc_seq_ctrl: per-instruction cycle traces built
// from timing rules, random ack latency and debug inputs.
module tb_punc_seq_ctrl;
  import punc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       ir = '0;
  logic              nzp_match = 1'b0;
  logic              mem_ack = 1'b0;
  logic              dbg_pause = 1'b0;
  logic              dbg_step = 1'b0;
  logic [CTRL_W-1:0] ctrl;
  logic              mem_req, mem_we;
  logic [3:0]        state_o;
  logic              halted, fault, retired;
  ctrl_t             cw;

  assign cw = ctrl_t'(ctrl);

  punc_seq_ctrl #(
    .DATA_W     (16),
    .MEM_TIMEOUT(4),
    .TMO_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .nzp_match(nzp_match),
    .mem_ack  (mem_ack),
    .dbg_pause(dbg_pause),
    .dbg_step (dbg_step),
    .ctrl     (ctrl),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .state_o  (state_o),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        req, we, ret, wr, pcld;
    logic [1:0]  ps;
    logic        ack, pause, step, nzp;
    logic [15:0] ir;
  } cyc_t;

  cyc_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          fix_lat = -1;
  logic [15:0] cur_ir = '0;
  logic        cur_nzp = 1'b0;
  string       cur_tag = "init";

  function automatic int pick_lat();
    if (fix_lat >= 0) return fix_lat;
    return int'($urandom_range(0, 4));
  endfunction

  task automatic push(input logic [3:0] st, input logic req, we, ret,
                      wr, pcld, input logic [1:0] ps, input logic ack);
    cyc_t c;
    c.st = st; c.req = req; c.we = we; c.ret = ret; c.wr = wr;
    c.pcld = pcld; c.ps = ps; c.ack = ack;
    c.pause = 1'($urandom_range(0, 1));
    c.step = 1'($urandom_range(0, 1));
    c.nzp = cur_nzp; c.ir = cur_ir;
    q.push_back(c);
  endtask

  task automatic set_last(input logic p, input logic s);
    cyc_t c;
    c = q.pop_back();
    c.pause = p; c.step = s;
    q.push_back(c);
  endtask

  task automatic mem_phase(input logic [3:0] st, input logic we,
                           input int lat, input logic wr, input logic ret);
    for (int i = 0; i < lat; i++)
      push(st, 1'b1, we, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    push(st, 1'b1, we, ret, wr, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic push_idle(input logic [3:0] st, input logic p,
                           input logic s, input logic ack);
    push(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ack);
    set_last(p, s);
  endtask

  task automatic plan_instr(input logic [15:0] inst, input logic nzp,
                            input logic pend);
    logic [3:0] op;
    cur_ir = inst; cur_nzp = nzp; op = inst[15:12];
    mem_phase(S_FETCH, 1'b0, pick_lat(), 1'b0, 1'b0);
    push(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    case (op)
      OP_LD, OP_LDR: mem_phase(S_EXEC, 1'b0, pick_lat(), 1'b1, 1'b1);
      OP_ST, OP_STR: mem_phase(S_EXEC, 1'b1, pick_lat(), 1'b0, 1'b1);
      OP_LDI: begin
        mem_phase(S_EXEC, 1'b0, pick_lat(), 1'b0, 1'b0);
        mem_phase(S_EXEC2, 1'b0, pick_lat(), 1'b1, 1'b1);
      end
      OP_STI: begin
        mem_phase(S_EXEC, 1'b0, pick_lat(), 1'b0, 1'b0);
        mem_phase(S_EXEC2, 1'b1, pick_lat(), 1'b0, 1'b1);
      end
      OP_JSR: begin
        push(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        push(S_EXEC2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
             inst[11] ? PC_SEL_OFF11 : PC_SEL_RF_R1, 1'b0);
      end
      OP_BR:  push(S_EXEC, 1'b0, 1'b0, 1'b1, 1'b0, nzp, PC_SEL_OFF9, 1'b0);
      OP_JMP: push(S_EXEC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, PC_SEL_RF_R1, 1'b0);
      OP_ADD, OP_AND, OP_NOT, OP_LEA:
        push(S_EXEC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      default: push(S_EXEC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    endcase
    set_last(pend, 1'($urandom_range(0, 1)));
  endtask

  task automatic check(input cyc_t c);
    logic [12:0] obs, exp;
    logic [1:0]  ops;
    ops = 2'b00;
    if (c.pcld) ops = cw.pc_sel;
    obs = {state_o, mem_req, mem_we & mem_req, retired, cw.rf_w_wr,
           cw.pc_ld, ops, halted, fault};
    exp = {c.st, c.req, c.we, c.ret, c.wr, c.pcld,
           c.pcld ? c.ps : 2'b00, c.st == S_HALT, c.st == S_FAULT};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s ir=%h obs=%h exp=%h", cur_tag, c.ir, obs, exp);
    end
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      ir = c.ir; nzp_match = c.nzp; mem_ack = c.ack;
      dbg_pause = c.pause; dbg_step = c.step;
      #1;
      check(c);
    end
  endtask

  task automatic chk_reset_out(input string tag);
    ctrl_t             e;
    logic [CTRL_W+7:0] obs, exp;
    e = '0;
    e.pc_clr = 1'b1; e.ir_clr = 1'b1; e.nzp_clr = 1'b1;
    obs = {ctrl, state_o, mem_req, halted, fault, retired};
    exp = {e, S_INIT, 4'b0000};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // reset asserted between clock edges, then released
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 chk_reset_out(tag);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    push_idle(S_INIT, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pause_cycles(input int n);
    for (int i = 0; i < n; i++) push_idle(S_PAUSE, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] inst;
    logic        pe;

    #3 chk_reset_out("reset_out");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    push_idle(S_INIT, 1'b0, 1'b0, 1'b0);

    cur_tag = "add_zero_wait";
    fix_lat = 0;
    plan_instr(16'h1263, 1'b0, 1'b0);
    run_q();

    cur_tag = "ldi_wait2";
    fix_lat = 2;
    plan_instr(16'hA405, 1'b0, 1'b0);
    run_q();

    cur_tag = "ack_at_timeout";
    fix_lat = 4;
    plan_instr(16'h2A10, 1'b0, 1'b0);
    run_q();

    cur_tag = "br_pause_step";
    fix_lat = -1;
    plan_instr(16'h0E03, 1'b1, 1'b1);
    pause_cycles(3);
    push_idle(S_PAUSE, 1'b1, 1'b1, 1'b0);
    plan_instr(16'h5A7F, 1'b0, 1'b1);
    pause_cycles(2);
    push_idle(S_PAUSE, 1'b0, 1'b0, 1'b0);
    run_q();

    cur_tag = "br_not_taken";
    plan_instr(16'h0E03, 1'b0, 1'b0);
    cur_tag = "jsr";
    plan_instr(16'h4080, 1'b0, 1'b0);
    plan_instr(16'h4812, 1'b0, 1'b0);
    plan_instr(16'hD000, 1'b0, 1'b0);
    run_q();

    cur_tag = "random";
    for (int n = 0; n < 60; n++) begin
      inst = 16'($urandom);
      inst[15:12] = 4'($urandom_range(0, 14));
      pe = ($urandom_range(0, 7) == 0);
      plan_instr(inst, 1'($urandom_range(0, 1)), pe);
      if (pe) begin
        pause_cycles(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 1) == 1)
          push_idle(S_PAUSE, 1'b1, 1'b1, 1'b0);
        else
          push_idle(S_PAUSE, 1'b0, 1'b0, 1'b0);
      end
      run_q();
    end

    cur_tag = "halt";
    plan_instr(16'hF025, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      push(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    set_last(1'b1, 1'b1);
    run_q();
    async_reset("reset_from_halt");

    cur_tag = "fetch_timeout";
    for (int i = 0; i < 5; i++)
      push(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      push_idle(S_FAULT, 1'b0, 1'b1, 1'b1);
    run_q();
    async_reset("reset_from_fault");

    cur_tag = "after_fault";
    fix_lat = 0;
    plan_instr(16'h1263, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      push(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_q();
    async_reset("reset_mid_fetch");
    run_q();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/punc_seq_ctrl.md
# punc_seq_ctrl

Parametrised, handshake-driven successor to the PUnC LC3 control FSM. Sequences fetch/decode/execute against a variable-latency memory port (req/ack) instead of single-cycle memory. Adds a memory-timeout fault, an explicit HALT state, debug pause/single-step, and an instruction-retired pulse. Sits between the PUnC datapath, which supplies `ir` and `nzp_match`, and the memory wrapper. It drives the same datapath control fields, packed into one control word.

## Interface
- `DATA_W`, 16: instruction/datapath width. Opcode is always `ir[DATA_W-1:DATA_W-4]`.
- `MEM_TIMEOUT`, 15: cycles a memory request may wait without ack before fault. 0 disables the timeout.
- `TMO_W`, 4: timeout counter width. Must satisfy 2^TMO_W > MEM_TIMEOUT.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `ir`  in  DATA_W  current instruction register contents.
- `nzp_match`  in  1  branch condition from the datapath NZP logic.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `dbg_pause`  in  1  level; park before the next fetch.
- `dbg_step`  in  1  pulse; execute exactly one instruction while parked.
- `ctrl`  out  CTRL_W  packed datapath controls: IR_clr/ld; PC_ld/clr/inc/sel; Mem_R/W_addr_sel; RF_W_data_sel, RF_W_addr_sel, RF_R0_addr_sel, RF_W_wr, RF_R0_rd, RF_R1_rd; prev_ld; nzp_ld/clr; ALU_sel; alu_first_val.
- `mem_req`  out  1  memory request active.
- `mem_we`  out  1  request is a write; valid only while `mem_req` is high.
- `state_o`  out  4  current state encoding, for debug.
- `halted`  out  1  in HALT.
- `fault`  out  1  in FAULT (sticky).
- `retired`  out  1  one-cycle pulse on the last cycle of each instruction.

## Operation
- States: INIT, FETCH, DECODE, EXEC, EXEC2, PAUSE, HALT, FAULT.
- INIT:
  - `ctrl` asserts only PC_clr, IR_clr and nzp_clr.
  - Next state is FETCH, or PAUSE if `dbg_pause` is high.
- FETCH:
  - `mem_req`=1, `mem_we`=0, read address select = PC.
  - IR_ld and PC_inc are asserted only in the cycle where `mem_ack`=1, which also moves the FSM to DECODE.
  - Without ack the FSM stays in FETCH.
- DECODE: all controls 0; always moves to EXEC.
- EXEC, non-memory opcodes (ADD, AND, NOT, BR, JMP, LEA):
  - Single cycle; control values identical to the original PUnC encoding.
  - BR asserts PC_ld only when `nzp_match`=1.
- EXEC, memory opcodes (LD, LDR, LDI first read, ST, STR, STI pointer read):
  - `mem_req`=1 and address select as in the original encoding; `mem_we`=1 for ST and STR only.
  - Register/NZP/prev writes (RF_W_wr, nzp_ld, prev_ld) are gated by `mem_ack`.
  - The FSM holds in EXEC until ack.
- EXEC2:
  - Used by JSR (PC update), LDI (indirect read) and STI (indirect write).
  - Memory-using EXEC2 follows the same ack-gated rule as EXEC.
  - JSR: PC_sel = PC+offset11 when `ir[11]`=1, otherwise RF_R1.
- HLT: EXEC pulses `retired`, then goes to HALT. HALT is left only by reset; `dbg_*` is ignored there.
- Undefined opcode (reserved 4'b1101): treated as NOP, one EXEC cycle, retired.
- End of instruction: next state is FETCH, or PAUSE if `dbg_pause`=1 in that cycle.
- PAUSE: all controls 0. `dbg_step`=1 or `dbg_pause`=0 moves to FETCH. A step runs one instruction and then re-evaluates `dbg_pause`.
- Timeout (when MEM_TIMEOUT>0):
  - Counter clears on entry to any `mem_req` cycle sequence and increments each cycle `mem_req`=1 && `mem_ack`=0.
  - When the counter equals MEM_TIMEOUT with no ack, the FSM goes to FAULT.
  - FAULT: all controls 0, `fault`=1, held until reset.

## Timing
- Reset (async assert):
  - state=INIT, counter=0.
  - Outputs during reset: `ctrl` = {PC_clr, IR_clr, nzp_clr}=1, others 0; `mem_req`=0, `halted`=0, `fault`=0, `retired`=0.
- Deassertion: INIT is held one clock, then FETCH.
- Zero-wait memory (ack in the first req cycle):
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ST/LDR/STR: 3 cycles. JSR: 4. LDI/STI: 4.
  - Each wait cycle adds 1.
- `retired` is high in the final execute cycle, coincident with the completing ack where applicable.
- An ack in the same cycle the counter reaches MEM_TIMEOUT completes normally; no fault.
- Reset mid-transaction drops `mem_req` asynchronously; no completion is reported.
- `dbg_step` outside PAUSE is ignored.

## Structure
- Shared package `punc_pkg`:
  - Opcode constants.
  - State enum.
  - `ctrl` field offsets/widths and CTRL_W.
  - Select encodings: PC_sel, Mem addr sel, RF sel, ALU_sel, alu_first_val.
- Natural sub-module: `punc_mem_timer`, the timeout counter with clear/enable/expire outputs.
- Output decode stays combinational from state, `ir`, `nzp_match` and `mem_ack`.

## Test plan
- Reset release, ADD R1,R1,#3 with ack in the first cycle -> FETCH/DECODE/EXEC in 3 cycles; RF_W_wr=1 in EXEC; `retired` pulses once.
- LDI with ack delayed 2 cycles on each read -> EXEC held 3 cycles, EXEC2 held 3 cycles; RF_W_wr asserted only in the final EXEC2 ack cycle.
- MEM_TIMEOUT=4, fetch never acked -> FAULT on the 5th FETCH cycle, `fault`=1, `mem_req`=0; a late ack is ignored until reset.
- `dbg_pause`=1 during BR (nzp_match=1) -> PC_ld in EXEC, then PAUSE. A `dbg_step` pulse -> exactly one further instruction, then back to PAUSE.
- HLT -> `retired` pulse, `halted`=1, stays HALT through `dbg_step`; async `rst` low mid-cycle -> INIT immediately, `halted`=0.
- BR with nzp_match=0 -> PC_ld=0, next state FETCH; JSR `ir[11]`=0 -> EXEC2 PC_sel=RF_R1.
